// File: rtl/io_port_bridge.sv
// io_port_bridge: byte bridge between the CPU I/O pins and an external host.
// The host-to-CPU FIFO feeds In_port and raises one interrupt pulse per byte.
// The CPU-to-host FIFO captures OUT bytes for the host to drain.
// The interrupt output is named int_req because "int" is a reserved word.
module io_port_bridge #(
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_wr_en,
    input  logic [7:0] host_wr_data,
    output logic       host_full,
    output logic [7:0] In_port,
    input  logic       cpu_in_ack,
    output logic       int_req,
    input  logic       hlt,
    input  logic [7:0] Out_port,
    input  logic       cpu_out_strobe,
    input  logic       host_rd_en,
    output logic [7:0] host_rd_data,
    output logic       host_rd_valid,
    output logic       in_ovf,
    output logic       out_ovf
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int OUT_CW = OUT_AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    // host-to-CPU FIFO
    logic [7:0]       in_mem [IN_DEPTH];
    logic [IN_AW-1:0] in_wr_ptr;
    logic [IN_AW-1:0] in_rd_ptr;
    logic [IN_CW-1:0] in_count;
    logic             in_empty;
    logic             in_push;
    logic             in_pop;

    // CPU-to-host FIFO
    logic [7:0]        out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_ptr;
    logic [OUT_AW-1:0] out_rd_ptr;
    logic [OUT_CW-1:0] out_count;
    logic              out_empty;
    logic              out_push;
    logic              out_pop;

    state_t state_q;
    state_t state_d;

    assign in_empty  = (in_count == '0);
    assign host_full = (in_count == IN_CW'(IN_DEPTH));
    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // alongside a pop is still accepted.
    assign in_pop    = cpu_in_ack && !in_empty;
    assign in_push   = host_wr_en && (!host_full || in_pop);
    assign In_port   = in_empty ? 8'h00 : in_mem[in_rd_ptr];

    assign out_empty     = (out_count == '0);
    assign host_rd_valid = !out_empty;
    assign out_pop       = host_rd_en && !out_empty;
    assign out_push      = cpu_out_strobe &&
                           ((out_count != OUT_CW'(OUT_DEPTH)) || out_pop);
    assign host_rd_data  = out_empty ? 8'h00 : out_mem[out_rd_ptr];

    // Input FIFO storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wr_ptr] <= host_wr_data;
    end

    // Input FIFO pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
            in_ovf    <= 1'b0;
        end else begin
            if (in_push) in_wr_ptr <= in_wr_ptr + IN_AW'(1);
            if (in_pop)  in_rd_ptr <= in_rd_ptr + IN_AW'(1);
            in_count <= in_count + IN_CW'(in_push) - IN_CW'(in_pop);
            if (host_wr_en && !in_push) in_ovf <= 1'b1;
        end
    end

    // Output FIFO storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wr_ptr] <= Out_port;
    end

    // Output FIFO pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else begin
            if (out_push) out_wr_ptr <= out_wr_ptr + OUT_AW'(1);
            if (out_pop)  out_rd_ptr <= out_rd_ptr + OUT_AW'(1);
            out_count <= out_count + OUT_CW'(out_push) - OUT_CW'(out_pop);
            if (cpu_out_strobe && !out_push) out_ovf <= 1'b1;
        end
    end

    // Interrupt FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Interrupt FSM next state; int_req decodes only the registered state.
    always_comb begin
        state_d = state_q;
        int_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (!in_empty && !hlt) state_d = PULSE;
            end
            PULSE: begin
                int_req = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Re-arm only when the ack actually removes a byte.
                if (cpu_in_ack && !in_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
